// File: rtl/matrix_scan.sv
// ============================================================================
// Module   : matrix_scan
// Brief    : Row-scanning driver for an 8x8 red/green LED matrix with
//            per-frame latching, row-change blanking and 4-level dimming.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_scan #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic         clk,
    input  logic         sw,
    input  logic [127:0] matrixData,
    input  logic [1:0]   level,
    output logic [7:0]   row,
    output logic [7:0]   colR,
    output logic [7:0]   colG,
    output logic         frame_start
);

    localparam int              c_CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DIV - 1);
    localparam logic [c_CW-1:0] c_BLANK   = c_CW'(BLANK);

    generate
        if ((BLANK < 1) || (DIV <= BLANK)) begin : g_bad_params
            $error("matrix_scan: requires BLANK >= 1 and DIV > BLANK");
        end
    endgenerate

    logic [c_CW-1:0] r_cnt_q,  w_cnt_d;
    logic [2:0]      r_ridx_q, w_ridx_d;
    logic [127:0]    r_fbuf_q, w_fbuf_d;
    logic [1:0]      r_lvl_q,  w_lvl_d;

    logic            w_row_end;
    logic            w_frame_top;
    logic            w_show;
    logic            w_on;
    logic [1:0]      w_cnt_lo;
    logic [15:0]     w_row_bits;

    // Dimming phase comes from the two LSBs of the row counter; pad when the
    // counter itself is narrower than that.
    generate
        if (c_CW >= 2) begin : g_cnt_lo_wide
            assign w_cnt_lo = r_cnt_q[1:0];
        end else begin : g_cnt_lo_narrow
            assign w_cnt_lo = {1'b0, r_cnt_q[0]};
        end
    endgenerate

    assign w_row_end   = (r_cnt_q == c_CNT_MAX);
    assign w_frame_top = (r_cnt_q == '0) && (r_ridx_q == 3'd0);

    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_ridx_d = r_ridx_q;
        w_fbuf_d = r_fbuf_q;
        w_lvl_d  = r_lvl_q;

        if (w_row_end) begin
            w_cnt_d  = '0;
            w_ridx_d = r_ridx_q + 3'd1;
        end else begin
            w_cnt_d  = r_cnt_q + 1'b1;
        end

        // Latch happens in a blanking cycle of row 0, so rows never mix frames.
        if (w_frame_top) begin
            w_fbuf_d = matrixData;
            w_lvl_d  = level;
        end
    end

    always_ff @(posedge clk) begin
        if (!sw) begin
            r_cnt_q  <= '0;
            r_ridx_q <= 3'd0;
            r_fbuf_q <= '0;
            r_lvl_q  <= 2'd0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_ridx_q <= w_ridx_d;
            r_fbuf_q <= w_fbuf_d;
            r_lvl_q  <= w_lvl_d;
        end
    end

    assign w_show     = (r_cnt_q >= c_BLANK);
    assign w_on       = (w_cnt_lo <= r_lvl_q);
    assign w_row_bits = r_fbuf_q[{r_ridx_q, 4'b0000} +: 16];

    // Row select stays asserted through dim-off cycles; only columns gate.
    always_comb begin
        row  = 8'hFF;
        colR = 8'h00;
        colG = 8'h00;
        if (w_show) begin
            row = ~(8'b0000_0001 << r_ridx_q);
            for (int k = 0; k < 8; k++) begin
                colR[k] = w_row_bits[2*k+1] & w_on;
                colG[k] = w_row_bits[2*k]   & w_on;
            end
        end
    end

    assign frame_start = w_frame_top;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan.sv
// ============================================================================
// Module   : tb_matrix_scan
// Brief    : Directed self-checking bench for matrix_scan with a frame-level
//            scan-position model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_scan;

    localparam int c_DIV   = 8;
    localparam int c_BLANK = 2;
    localparam int c_FRAME = 8 * c_DIV;

    logic         clk;
    logic         sw;
    logic [127:0] matrixData;
    logic [1:0]   level;
    logic [7:0]   row;
    logic [7:0]   colR;
    logic [7:0]   colG;
    logic         frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    matrix_scan #(
        .DIV   (c_DIV),
        .BLANK (c_BLANK)
    ) u_dut (
        .clk         (clk),
        .sw          (sw),
        .matrixData  (matrixData),
        .level       (level),
        .row         (row),
        .colR        (colR),
        .colG        (colG),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a single scan position 0..63 within the frame plus the latched image.
    int           m_pos   = 0;
    logic [127:0] m_fbuf  = '0;
    logic [1:0]   m_lvl   = 2'd0;
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        if (!sw) begin
            m_pos   = 0;
            m_fbuf  = '0;
            m_lvl   = 2'd0;
            m_valid = 1'b1;
        end else begin
            if (m_pos == 0) begin
                m_fbuf = matrixData;
                m_lvl  = level;
            end
            m_pos = (m_pos + 1) % c_FRAME;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int         phase;
            int         r;
            bit         show;
            bit         on;
            logic [7:0] e_row;
            logic [7:0] e_r;
            logic [7:0] e_g;
            phase = m_pos % c_DIV;
            r     = m_pos / c_DIV;
            show  = (phase >= c_BLANK);
            on    = ((phase % 4) <= int'(m_lvl));
            e_row = show ? ~(8'(1) << r) : 8'hFF;
            for (int k = 0; k < 8; k++) begin
                e_r[k] = show & on & m_fbuf[2*(8*r+k)+1];
                e_g[k] = show & on & m_fbuf[2*(8*r+k)];
            end
            chk("model_row",  row,  e_row);
            chk("model_colR", colR, e_r);
            chk("model_colG", colG, e_g);
            chk("model_frame_start", {7'd0, frame_start}, {7'd0, (m_pos == 0)});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!frame_start && c < 2 * c_FRAME);
        if (!frame_start) chk("wait_frame_start_timeout", 8'd0, 8'd1);
    endtask

    initial begin
        int period;
        sw         = 1'b0;
        matrixData = '1;
        level      = 2'd3;

        // Reset hold
        repeat (5) begin
            @(negedge clk);
            chk("rst_row", row, 8'hFF);
            chk("rst_colR", colR, 8'h00);
            chk("rst_colG", colG, 8'h00);
            chk("rst_frame_start", {7'd0, frame_start}, 8'd1);
        end
        sw = 1'b1;
        step(1);
        chk("rel_fs_fall", {7'd0, frame_start}, 8'd0);
        chk("rel_row_blank", row, 8'hFF);
        step(1);
        chk("rel_row0", row, 8'hFE);
        chk("rel_colR_full", colR, 8'hFF);
        chk("rel_colG_full", colG, 8'hFF);

        // Full yellow: frame period
        wait_fs();
        period = 0;
        do begin
            @(negedge clk);
            period++;
        end while (!frame_start && period < 2 * c_FRAME);
        chk("fs_period", 8'(period), 8'd64);

        // Single pixel: red at row 3 col 5, latched at this frame boundary
        matrixData = '0;
        matrixData[2*(8*3+5)+1] = 1'b1;
        step(18);
        chk("px_row2_colR", colR, 8'h00);
        step(6);
        chk("px_row3_blank", row, 8'hFF);
        step(2);
        chk("px_row3_row", row, 8'hF7);
        chk("px_row3_colR", colR, 8'h20);
        chk("px_row3_colG", colG, 8'h00);

        // Tear-free: dark frame, then all ones arriving mid-frame
        matrixData = '0;
        wait_fs();
        step(33);
        matrixData = '1;
        step(1);
        chk("tear_row4_row", row, 8'hEF);
        chk("tear_row4_colR", colR, 8'h00);
        step(24);
        chk("tear_row7_row", row, 8'h7F);
        chk("tear_row7_colG", colG, 8'h00);
        wait_fs();
        step(2);
        chk("tear_next_row", row, 8'hFE);
        chk("tear_next_colR", colR, 8'hFF);

        // Dimming at level 0: lit only at cnt=4
        level = 2'd0;
        wait_fs();
        step(2);
        chk("dim_c2_row", row, 8'hFE);
        chk("dim_c2_colR", colR, 8'h00);
        step(2);
        chk("dim_c4_colR", colR, 8'hFF);
        chk("dim_c4_colG", colG, 8'hFF);
        step(1);
        chk("dim_c5_row", row, 8'hFE);
        chk("dim_c5_colR", colR, 8'h00);
        step(7);
        chk("dim_r1c4_row", row, 8'hFD);
        chk("dim_r1c4_colR", colR, 8'hFF);
        step(1);
        chk("dim_r1c5_colG", colG, 8'h00);

        // Mid-frame reset at ridx=5, cnt=6
        step(33);
        chk("mid_pre_row", row, 8'hDF);
        sw         = 1'b0;
        matrixData = {16{8'h5A}};
        level      = 2'd3;
        step(1);
        chk("mid_rst_row", row, 8'hFF);
        chk("mid_rst_fs", {7'd0, frame_start}, 8'd1);
        chk("mid_rst_colR", colR, 8'h00);
        sw = 1'b1;
        step(1);
        chk("mid_rel_fs", {7'd0, frame_start}, 8'd0);
        step(1);
        chk("mid_restart_row", row, 8'hFE);
        chk("mid_restart_colR", colR, 8'h33);
        chk("mid_restart_colG", colG, 8'hCC);

        step(c_FRAME);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
